// File: rtl/tmr_multi.sv
// Multi-channel tick timer: a free-running tick counter plus NUM_CH down-counting
// compare channels with maskable interrupts, on a zero-wait-state register bus.
module tmr_multi #(
    parameter int PRESCALE = 50000,
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    output logic        irq
);
    localparam int               PSC_W   = $clog2(PRESCALE);
    localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);

    logic [PSC_W-1:0]  psc;
    logic              tick;
    logic [CNT_W-1:0]  ticks;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] ien;
    logic [NUM_CH-1:0] run;
    logic [NUM_CH-1:0] periodic;
    logic [CNT_W-1:0]  reload [NUM_CH];
    logic [CNT_W-1:0]  cur    [NUM_CH];

    logic              wr;
    logic              wr_ticks;
    logic              wr_pend;
    logic              wr_ien;
    logic [NUM_CH-1:0] wr_ctrl;
    logic [NUM_CH-1:0] wr_reload;
    logic [NUM_CH-1:0] expire;

    assign ack      = stb;
    assign wr       = stb & we;
    assign wr_ticks = wr && (addr == 4'd0);
    assign wr_pend  = wr && (addr == 4'd1);
    assign wr_ien   = wr && (addr == 4'd2);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latches).
        wr_ctrl   = '0;
        wr_reload = '0;
        expire    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_ctrl[i]   = wr && (addr == 4'(4 + 3 * i));
            wr_reload[i] = wr && (addr == 4'(5 + 3 * i));
            expire[i]    = tick && run[i] && (cur[i] == CNT_W'(1));
        end
    end

    always_comb begin
        data_out = '0;
        case (addr)
            4'd0: data_out[CNT_W-1:0]  = ticks;
            4'd1: data_out[NUM_CH-1:0] = pend;
            4'd2: data_out[NUM_CH-1:0] = ien;
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (addr == 4'(4 + 3 * i)) data_out[1:0] = {periodic[i], run[i]};
                    if (addr == 4'(5 + 3 * i)) data_out[CNT_W-1:0] = reload[i];
                    if (addr == 4'(6 + 3 * i)) data_out[CNT_W-1:0] = cur[i];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psc   <= '0;
            tick  <= 1'b0;
            ticks <= '0;
            pend  <= '0;
            ien   <= '0;
            irq   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every update in this edge sees pre-edge values.
            psc  <= (psc == PSC_MAX) ? '0 : psc + 1'b1;
            tick <= (psc == PSC_MAX);
            if (wr_ticks)  ticks <= data_in[CNT_W-1:0];
            else if (tick) ticks <= ticks + 1'b1;
            // Expiry is OR-ed in after the clear so a same-cycle W1C cannot hide it.
            pend <= (pend & ~(wr_pend ? data_in[NUM_CH-1:0] : '0)) | expire;
            if (wr_ien) ien <= data_in[NUM_CH-1:0];
            irq <= |(pend & ien);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run      <= '0;
            periodic <= '0;
            // NOTE: the channel arrays are a few flops, not a RAM, so they are reset like any register.
            for (int i = 0; i < NUM_CH; i++) begin
                reload[i] <= '0;
                cur[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_reload[i]) begin
                    reload[i] <= data_in[CNT_W-1:0];
                    cur[i]    <= data_in[CNT_W-1:0];
                end else if (tick && run[i] && (cur[i] != '0)) begin
                    if (cur[i] == CNT_W'(1)) cur[i] <= periodic[i] ? reload[i] : '0;
                    else                     cur[i] <= cur[i] - 1'b1;
                end
                if (wr_ctrl[i]) begin
                    run[i]      <= data_in[0];
                    periodic[i] <= data_in[1];
                end else if (expire[i] && !periodic[i]) begin
                    run[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_tmr_multi.sv
// Randomized bench for tmr_multi, checked cycle by cycle against a reference
// model derived from the register-map rules, plus a narrow-counter instance.
module tb_tmr_multi;
    localparam int P   = 10;
    localparam int NCH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  addr = 4'd0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic        ack;
    logic        irq;

    logic        stb8 = 1'b0;
    logic        we8 = 1'b0;
    logic [3:0]  addr8 = 4'd0;
    logic [31:0] data8 = '0;
    logic [31:0] dout8;
    logic        ack8;
    logic        irq8;

    tmr_multi #(.PRESCALE(P), .NUM_CH(NCH), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stb(stb), .we(we), .addr(addr), .data_in(data_in),
        .data_out(data_out), .ack(ack), .irq(irq)
    );

    tmr_multi #(.PRESCALE(P), .NUM_CH(1), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .stb(stb8), .we(we8), .addr(addr8), .data_in(data8),
        .data_out(dout8), .ack(ack8), .irq(irq8)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: n counts rising edges since reset release.
    int unsigned       n;
    logic [31:0]       m_ticks;
    logic [NCH-1:0]    m_pend;
    logic [NCH-1:0]    m_ien;
    logic              m_irq;
    logic [31:0]       m_rel [NCH];
    logic [31:0]       m_cur [NCH];
    bit                m_run [NCH];
    bit                m_per [NCH];

    // Tick is high during the cycle after every P-th edge.
    function automatic bit tick_now();
        return (n > 0) && (n % P == 0);
    endfunction

    task automatic model_reset();
        n = 0; m_ticks = '0; m_pend = '0; m_ien = '0; m_irq = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            m_rel[i] = '0; m_cur[i] = '0; m_run[i] = 1'b0; m_per[i] = 1'b0;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] a);
        logic [31:0] r;
        int          ai;
        r  = '0;
        ai = int'(a);
        if (ai == 0)      r = m_ticks;
        else if (ai == 1) r = 32'(m_pend);
        else if (ai == 2) r = 32'(m_ien);
        else if (ai >= 4 && (ai - 4) / 3 < NCH) begin
            case ((ai - 4) % 3)
                0:       r = {30'b0, m_per[(ai - 4) / 3], m_run[(ai - 4) / 3]};
                1:       r = m_rel[(ai - 4) / 3];
                default: r = m_cur[(ai - 4) / 3];
            endcase
        end
        return r;
    endfunction

    task automatic model_step(input logic s, input logic w, input logic [3:0] a, input logic [31:0] d);
        bit             tk;
        bit             wr;
        logic [NCH-1:0] ex;
        int             ai;
        tk = tick_now();
        wr = s && w;
        ai = int'(a);
        ex = '0;
        for (int i = 0; i < NCH; i++) ex[i] = tk && m_run[i] && (m_cur[i] == 1);
        m_irq = |(m_pend & m_ien);
        if (wr && ai == 0) m_ticks = d;
        else if (tk)       m_ticks = m_ticks + 1;
        if (wr && ai == 1) m_pend = m_pend & ~d[NCH-1:0];
        m_pend = m_pend | ex;
        if (wr && ai == 2) m_ien = d[NCH-1:0];
        for (int i = 0; i < NCH; i++) begin
            if (wr && ai == 5 + 3 * i) begin
                m_rel[i] = d;
                m_cur[i] = d;
            end else if (tk && m_run[i] && m_cur[i] != 0) begin
                m_cur[i] = (m_cur[i] == 1) ? (m_per[i] ? m_rel[i] : 32'd0) : m_cur[i] - 1;
            end
            if (wr && ai == 4 + 3 * i) begin
                m_run[i] = d[0];
                m_per[i] = d[1];
            end else if (ex[i] && !m_per[i]) begin
                m_run[i] = 1'b0;
            end
        end
        n++;
    endtask

    // One bus cycle: drive after the edge, compare on the falling edge, advance the model.
    task automatic do_cycle(input logic s, input logic w, input logic [3:0] a, input logic [31:0] d);
        stb = s; we = w; addr = a; data_in = d;
        @(negedge clk);
        check("ack", ack, s);
        check("irq", irq, m_irq);
        check("rdata", data_out, model_read(a));
        @(posedge clk);
        model_step(s, w, a, d);
        #1;
    endtask

    task automatic idle();
        do_cycle(1'b0, 1'b0, 4'($urandom_range(0, 15)), '0);
    endtask

    logic [3:0]  ra;
    logic        rw;
    logic [31:0] rd;
    int          ai;
    bit          found;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_irq", irq, 0);
        check("rst_ticks", data_out, 0);
        rst = 1'b1;
        model_reset();

        // Free-running tick counter.
        repeat (101) do_cycle(1'b0, 1'b0, 4'd0, '0);
        addr = 4'd0; #1;
        check("ticks_after_101", data_out, 32'd10);

        // Channel 0 periodic, period 3 ticks.
        do_cycle(1'b1, 1'b1, 4'd5, 32'd3);
        do_cycle(1'b1, 1'b1, 4'd4, 32'd3);
        do_cycle(1'b1, 1'b1, 4'd2, 32'd1);
        repeat (70) do_cycle(1'b0, 1'b0, 4'd6, '0);
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (m_cur[0] == 3 && m_pend[0]) found = 1'b1;
            else do_cycle(1'b0, 1'b0, 4'd6, '0);
        end
        check("ch0_reload_timeout", found, 1);
        idle();
        check("irq_on", irq, 1);
        do_cycle(1'b1, 1'b1, 4'd1, 32'd1);
        idle();
        check("irq_cleared", irq, 0);

        // Channel 1 one-shot.
        do_cycle(1'b1, 1'b1, 4'd8, 32'd2);
        do_cycle(1'b1, 1'b1, 4'd7, 32'd1);
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (!m_run[1]) found = 1'b1;
            else do_cycle(1'b0, 1'b0, 4'd9, '0);
        end
        check("ch1_expire_timeout", found, 1);
        addr = 4'd7; #1;
        check("ch1_ctrl_after", data_out, 0);
        addr = 4'd9; #1;
        check("ch1_cur_after", data_out, 0);
        do_cycle(1'b1, 1'b1, 4'd1, 32'd2);
        repeat (100) idle();
        addr = 4'd1; #1;
        check("ch1_no_repend", data_out & 32'd2, 0);

        // Expiry coinciding with W1C of the same bit.
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (tick_now() && m_run[0] && m_cur[0] == 1) found = 1'b1;
            else idle();
        end
        check("ch0_expiry_timeout", found, 1);
        do_cycle(1'b1, 1'b1, 4'd1, 32'd1);
        addr = 4'd1; #1;
        check("pend_set_wins", data_out & 32'd1, 1);

        // TICKS write in a tick cycle.
        found = 1'b0;
        for (int c = 0; c < 2 * P && !found; c++) begin
            if (tick_now()) found = 1'b1;
            else idle();
        end
        check("tick_wait_timeout", found, 1);
        do_cycle(1'b1, 1'b1, 4'd0, 32'd5);
        addr = 4'd0; #1;
        check("ticks_write_wins", data_out, 5);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                ra = 4'($urandom_range(0, 15));
                rw = 1'($urandom_range(0, 1));
                ai = int'(ra);
                if (ai == 0)                        rd = $urandom;
                else if (ai >= 4 && (ai - 4) % 3 == 1) rd = $urandom_range(0, 6);
                else if (ai >= 4 && (ai - 4) % 3 == 0) rd = $urandom_range(0, 3);
                else                                rd = $urandom_range(0, 15);
                do_cycle(1'b1, rw, ra, rd);
            end else begin
                idle();
            end
        end

        // Narrow counter wrap and unmapped address on the 8-bit instance.
        stb8 = 1'b1; we8 = 1'b1; addr8 = 4'd0; data8 = 32'd255; #1;
        check("ack8_on", ack8, 1);
        idle();
        stb8 = 1'b0; we8 = 1'b0; #1;
        check("ack8_off", ack8, 0);
        check("ticks8_loaded", dout8, 255);
        found = 1'b0;
        for (int c = 0; c < 2 * P + 2 && !found; c++) begin
            idle();
            if (dout8 != 32'd255) found = 1'b1;
        end
        check("ticks8_tick_timeout", found, 1);
        check("ticks8_wrap", dout8, 0);
        stb8 = 1'b1; we8 = 1'b1; addr8 = 4'd3; data8 = 32'hFFFF_FFFF; #1;
        check("ack8_unmapped", ack8, 1);
        check("unmapped8_read", dout8, 0);
        idle();
        stb8 = 1'b0; we8 = 1'b0; #1;
        check("unmapped8_after", dout8, 0);

        // Asynchronous reset mid-count with irq high.
        do_cycle(1'b1, 1'b1, 4'd2, 32'd3);
        do_cycle(1'b1, 1'b1, 4'd5, 32'd2);
        do_cycle(1'b1, 1'b1, 4'd4, 32'd3);
        found = 1'b0;
        for (int c = 0; c < 80 && !found; c++) begin
            if (m_irq) found = 1'b1;
            else idle();
        end
        check("irq_wait_timeout", found, 1);
        check("irq_before_reset", irq, 1);
        #2;
        rst = 1'b0;
        #1;
        check("reset_irq", irq, 0);
        for (int a = 0; a < 16; a++) begin
            addr = 4'(a); #1;
            check("reset_regs", data_out, 0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        repeat (30) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
